lsu_controller: RTL and testbench

LSU_CONTROLLER -- requirements
Module: lsu_controller

---
 rtl/lsu_controller.sv | 173 +++++++++++++++++
 tb/tb_lsu_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_controller.sv
// Load/store unit bus sequencer: checks size and alignment, drives a single-beat bus access
// and formats load data.
// state     | meaning
// IDLE      | waiting for mem_read/mem_write; faults are flagged here
// REQ       | bus_req asserted with latched address/enables until bus_gnt
// WAIT_RESP | load granted, waiting for bus_rvalid
// DONE      | one unstalled cycle; load_valid or bus_err reported here
module lsu_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        access_fault,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES);

  logic [1:0]    state, state_nxt;
  logic [31:0]   lat_addr;
  logic [2:0]    lat_func3;
  logic          lat_we;
  logic [3:0]    lat_be;
  logic [31:0]   lat_wdata;
  logic [CW-1:0] cnt;
  logic [31:0]   load_data_q;
  logic          bus_err_q;

  logic        req_any;
  logic        f3_illegal;
  logic        misalign;
  logic        fault_req;
  logic        accept;
  logic        timeout;
  logic        to_abort;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] rd_byte_sh;
  logic [31:0] rd_half_sh;
  logic [31:0] rd_fmt;

  // Request decode; a simultaneous read+write is handled as a store.
  assign req_any    = mem_read | mem_write;
  assign f3_illegal = (func3 == 3'b011) | (func3 == 3'b110) | (func3 == 3'b111);
  assign misalign   = ((func3[1:0] == 2'b01) & addr[0]) |
                      ((func3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign fault_req  = req_any & (f3_illegal | misalign);
  assign accept     = (state == S_IDLE) & req_any & ~fault_req;

  always_comb begin
    be_new = 4'b1111;
    case (func3[1:0])
      2'b00:   be_new = 4'b0001 << addr[1:0];
      2'b01:   be_new = addr[1] ? 4'b1100 : 4'b0011;
      default: be_new = 4'b1111;
    endcase
  end

  always_comb begin
    wdata_new = 32'd0;
    if (mem_write) begin
      case (func3[1:0])
        2'b00:   wdata_new = {4{wdata[7:0]}};
        2'b01:   wdata_new = {2{wdata[15:0]}};
        default: wdata_new = wdata;
      endcase
    end
  end

  // Lane select for loads uses the latched address, not the live one.
  assign rd_byte_sh = bus_rdata >> {lat_addr[1:0], 3'b000};
  assign rd_half_sh = bus_rdata >> {lat_addr[1], 4'b0000};

  always_comb begin
    rd_fmt = bus_rdata;
    case (lat_func3)
      3'b000:  rd_fmt = {{24{rd_byte_sh[7]}}, rd_byte_sh[7:0]};
      3'b001:  rd_fmt = {{16{rd_half_sh[15]}}, rd_half_sh[15:0]};
      3'b100:  rd_fmt = {24'd0, rd_byte_sh[7:0]};
      3'b101:  rd_fmt = {16'd0, rd_half_sh[15:0]};
      default: rd_fmt = bus_rdata;
    endcase
  end

  // Budget is shared between REQ and WAIT_RESP; grant/rvalid on the last cycle still wins.
  assign timeout  = (cnt >= TO_LAST);
  assign to_abort = timeout & (((state == S_REQ) & ~bus_gnt) |
                               ((state == S_WAIT) & ~bus_rvalid));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_REQ;
      S_REQ: begin
        if (bus_gnt)      state_nxt = lat_we ? S_DONE : S_WAIT;
        else if (timeout) state_nxt = S_DONE;
      end
      S_WAIT: begin
        if (bus_rvalid)   state_nxt = S_DONE;
        else if (timeout) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lat_addr    <= 32'd0;
      lat_func3   <= 3'd0;
      lat_we      <= 1'b0;
      lat_be      <= 4'd0;
      lat_wdata   <= 32'd0;
      cnt         <= '0;
      load_data_q <= 32'd0;
      bus_err_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bus_err_q <= to_abort;
      if (accept) begin
        lat_addr  <= addr;
        lat_func3 <= func3;
        lat_we    <= mem_write;
        lat_be    <= be_new;
        lat_wdata <= wdata_new;
        cnt       <= '0;
      end else if (((state == S_REQ) | (state == S_WAIT)) & (cnt != TO_MAX)) begin
        cnt <= cnt + 1'b1;
      end
      if ((state == S_WAIT) & bus_rvalid) begin
        load_data_q <= rd_fmt;
      end else if (to_abort) begin
        load_data_q <= 32'd0;
      end
    end
  end

  // stall and access_fault decode live inputs, so gate them during reset.
  assign stall        = rst_n & (accept | (state == S_REQ) | (state == S_WAIT));
  assign access_fault = rst_n & (state == S_IDLE) & fault_req;
  assign load_valid   = (state == S_DONE) & ~lat_we & ~bus_err_q;
  assign load_data    = load_data_q;
  assign bus_err      = bus_err_q;
  assign bus_req      = (state == S_REQ);
  assign bus_we       = bus_req & lat_we;
  assign bus_addr     = bus_req ? {lat_addr[31:2], 2'b00} : 32'd0;
  assign bus_be       = bus_req ? lat_be : 4'd0;
  assign bus_wdata    = bus_req ? lat_wdata : 32'd0;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: stores, loads, faults, timeout and reset mid-access.
module tb_lsu_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic        stall, load_valid, access_fault, bus_err;
  logic [31:0] load_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_err = 0;

  lsu_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .func3(func3),
    .addr(addr), .wdata(wdata),
    .stall(stall), .load_valid(load_valid), .load_data(load_data),
    .access_fault(access_fault), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic do_store(input logic also_rd, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be, input logic [31:0] bw);
    @(negedge clk);
    mem_write = 1'b1; mem_read = also_rd; func3 = f3; addr = a; wdata = d;
    #1;
    chk1("st_accept_stall", stall, 1'b1);
    chk1("st_accept_noreq", bus_req, 1'b0);
    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b0; bus_gnt = 1'b1;
    #1;
    chk1("st_req", bus_req, 1'b1);
    chk1("st_we", bus_we, 1'b1);
    check("st_be", 32'(bus_be), 32'(be));
    check("st_addr", bus_addr, {a[31:2], 2'b00});
    check("st_wdata", bus_wdata, bw);
    chk1("st_req_stall", stall, 1'b1);
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    chk1("st_done_stall", stall, 1'b0);
    chk1("st_done_lv", load_valid, 1'b0);
    chk1("st_done_req", bus_req, 1'b0);
    @(negedge clk);
    #1;
    chk1("st_idle_stall", stall, 1'b0);
    chk1("st_idle_req", bus_req, 1'b0);
  endtask

  // Also releases reset on its first edge so a post-reset load is taken on the first rising edge.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                         input logic [3:0] be, input logic [31:0] exp);
    @(negedge clk);
    rst_n = 1'b1; mem_read = 1'b1; func3 = f3; addr = a;
    #1;
    chk1("ld_accept_stall", stall, 1'b1);
    @(negedge clk);
    mem_read = 1'b0; bus_gnt = 1'b1;
    #1;
    chk1("ld_req", bus_req, 1'b1);
    chk1("ld_we", bus_we, 1'b0);
    check("ld_be", 32'(bus_be), 32'(be));
    check("ld_wdata", bus_wdata, 32'd0);
    check("ld_addr", bus_addr, {a[31:2], 2'b00});
    @(negedge clk);
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = rd;
    #1;
    chk1("ld_wait_stall", stall, 1'b1);
    chk1("ld_wait_req", bus_req, 1'b0);
    chk1("ld_wait_lv", load_valid, 1'b0);
    @(negedge clk);
    bus_rvalid = 1'b0; bus_rdata = 32'd0;
    #1;
    chk1("ld_done_lv", load_valid, 1'b1);
    check("ld_data", load_data, exp);
    chk1("ld_done_stall", stall, 1'b0);
    @(negedge clk);
    #1;
    chk1("ld_idle_lv", load_valid, 1'b0);
    check("ld_hold", load_data, exp);
  endtask

  task automatic do_fault(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    mem_read = rd; mem_write = wr; func3 = f3; addr = a;
    #1;
    chk1("flt_fault", access_fault, 1'b1);
    chk1("flt_stall", stall, 1'b0);
    chk1("flt_req", bus_req, 1'b0);
    @(negedge clk);
    #1;
    chk1("flt_req_next", bus_req, 1'b0);
    chk1("flt_fault_hold", access_fault, 1'b1);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    chk1("flt_clear", access_fault, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0; func3 = 3'b010;
    addr = 32'h101; wdata = 32'd0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
    #1;
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_fault", access_fault, 1'b0);
    chk1("rst_req", bus_req, 1'b0);
    chk1("rst_lv", load_valid, 1'b0);
    chk1("rst_err", bus_err, 1'b0);
    check("rst_ld", load_data, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_be", 32'(bus_be), 32'd0);
    @(negedge clk);
    mem_read = 1'b0;
    @(negedge clk);

    // first load right after reset release
    do_load(3'b010, 32'h100, 32'h11223344, 4'b1111, 32'h11223344);
    do_store(1'b0, 3'b010, 32'h104, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);
    do_load(3'b000, 32'h203, 32'h80FF_0000, 4'b1000, 32'hFFFFFF80);
    do_load(3'b100, 32'h203, 32'h80FF_0000, 4'b1000, 32'h00000080);
    do_store(1'b0, 3'b001, 32'h102, 32'h0000ABCD, 4'b1100, 32'hABCDABCD);
    do_store(1'b0, 3'b000, 32'h101, 32'h12345677, 4'b0010, 32'h77777777);
    do_store(1'b1, 3'b000, 32'h106, 32'h000000A5, 4'b0100, 32'hA5A5A5A5);
    do_load(3'b001, 32'h202, 32'h80FF_0000, 4'b1100, 32'hFFFF80FF);
    do_load(3'b101, 32'h200, 32'h1234F00D, 4'b0011, 32'h0000F00D);

    do_fault(1'b1, 1'b0, 3'b010, 32'h101);
    do_fault(1'b0, 1'b1, 3'b001, 32'h103);
    do_fault(1'b1, 1'b0, 3'b011, 32'h100);
    do_fault(1'b1, 1'b0, 3'b110, 32'h100);

    // timeout: grant withheld for the whole budget
    @(negedge clk);
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h300;
    #1;
    chk1("to_accept_stall", stall, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      mem_read = 1'b0;
      #1;
      check("to_req_wait", {30'd0, bus_req, bus_err}, 32'd2);
    end
    @(negedge clk);
    #1;
    chk1("to_err", bus_err, 1'b1);
    check("to_ld_zero", load_data, 32'd0);
    chk1("to_lv", load_valid, 1'b0);
    chk1("to_stall", stall, 1'b0);
    @(negedge clk);
    #1;
    chk1("to_err_pulse", bus_err, 1'b0);
    chk1("to_idle_req", bus_req, 1'b0);

    // grant on the final budget cycle wins over the timeout
    @(negedge clk);
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h304;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      mem_read = 1'b0;
      #1;
      chk1("lg_req", bus_req, 1'b1);
    end
    @(negedge clk);
    bus_gnt = 1'b1;
    #1;
    chk1("lg_req_last", bus_req, 1'b1);
    @(negedge clk);
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    #1;
    chk1("lg_wait_stall", stall, 1'b1);
    chk1("lg_wait_err", bus_err, 1'b0);
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    chk1("lg_lv", load_valid, 1'b1);
    chk1("lg_err", bus_err, 1'b0);
    check("lg_data", load_data, 32'hCAFEF00D);

    // reset while waiting for read data
    @(negedge clk);
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    mem_read = 1'b0; bus_gnt = 1'b1;
    #1;
    chk1("rw_req", bus_req, 1'b1);
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    chk1("rw_wait_stall", stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rw_rst_req", bus_req, 1'b0);
    chk1("rw_rst_stall", stall, 1'b0);
    check("rw_rst_ld", load_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    #1;
    chk1("rw_lv0", load_valid, 1'b0);
    chk1("rw_stall0", stall, 1'b0);
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    chk1("rw_lv1", load_valid, 1'b0);
    check("rw_ld", load_data, 32'd0);
    chk1("rw_req1", bus_req, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
